cmp_pool_sched: RTL and testbench
=================================

CMP_POOL_SCHED -- requirements
Module: cmp_pool_sched

Interface
REQ-001 Parameter DATA_W, default 4: width of every data value and of the max result.
REQ-002 Parameter WIN_W, default 3: width of the window-length config field.
REQ-003 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1: asynchronous, active-low reset; the block is in reset while rst=0.
REQ-005 Port cfg_win  input  WIN_W: pooling window length in beats; value 0 SHALL be treated as 1.
REQ-006 Ports req0_valid, req1_valid  input  1: requester N presents a beat.
REQ-007 Ports req0_data, req1_data  input  DATA_W: requester N beat value, unsigned.
REQ-008 Ports req0_ready, req1_ready  output  1: beat from requester N accepted when valid&ready.
REQ-009 Port out_valid  output  1: pooled result available.
REQ-010 Port out_ready  input  1: downstream accepts the result when out_valid&out_ready.
REQ-011 Port out_data  output  DATA_W: maximum of the completed window.
REQ-012 Port out_src  output  1: index of the requester that produced out_data.
REQ-013 Port busy  output  1: high in any state other than IDLE.

Function
REQ-014 FSM states SHALL be IDLE, ACCUM, DONE.
REQ-015 IDLE: both readys 0; if any reqN_valid=1, register the grant, latch cfg_win (0->1) into win_len, clear beat count, and go to ACCUM on the next edge.
REQ-016 Arbitration SHALL be round-robin: if only one request is valid, grant it; if both are valid, grant the requester that did not win the previous grant.
REQ-017 ACCUM: reqN_ready=1 only for the granted N; the ungranted requester's ready SHALL stay 0.
REQ-018 The first accepted beat of a window SHALL load max_reg=data; each later beat SHALL set max_reg=max(max_reg,data), unsigned compare; on equal values max_reg keeps its value.
REQ-019 Cycles with granted valid=0 SHALL stall: no count change, no max update, state held.
REQ-020 The beat count SHALL increment per accepted beat; on acceptance of beat win_len, go to DONE on the next edge.
REQ-021 A cfg_win change after the grant SHALL NOT affect the current window.
REQ-022 DONE: out_valid=1, out_data=max_reg, out_src=grant, both readys 0; out_data/out_src stable while out_valid=1 and out_ready=0.
REQ-023 On out_valid&out_ready: record grant as last winner, go to IDLE; out_valid=0 on the next cycle.
REQ-024 Latency: with continuous valid and out_ready=1, out_valid SHALL rise 1 cycle after the last beat is accepted; back-to-back windows SHALL cost win_len+2 cycles each (IDLE, win_len ACCUM, DONE).
REQ-025 If out_ready=1 already when DONE is entered, the result SHALL be handed off in that single DONE cycle.
REQ-026 Window of length 1 SHALL output exactly the single accepted beat.
REQ-027 Requests arriving in ACCUM or DONE from the ungranted requester SHALL wait, not be lost; data is held by the requester.

Reset
REQ-028 While rst=0: state=IDLE, out_valid=0, out_data=0, out_src=0, req0_ready=0, req1_ready=0, busy=0, max_reg=0, count=0.
REQ-029 Reset SHALL set last winner=1 so requester 0 wins the first simultaneous request.
REQ-030 Reset asserted mid-window or in DONE SHALL discard the partial or unaccepted result; no out_valid after release until a new full window completes.

Verification
REQ-031 cfg_win=3, req0 streams 1,3,2 continuous, out_ready=1 -> out_valid one cycle after beat 3, out_data=3, out_src=0.
REQ-032 Both valid from reset, cfg_win=2, req0 values 5,9, req1 values 7,4 -> first result 9/src0, second result 7/src1; req1_ready stays 0 during the req0 window.
REQ-033 cfg_win=0, req1 sends 6 -> out_data=6, out_src=1 after one beat.
REQ-034 cfg_win=4, req0 sends 2, gap 3 cycles valid=0, then 15,15,0 -> out_data=15; count holds during gap; cfg_win changed to 1 mid-window has no effect.
REQ-035 DONE with out_ready=0 for 5 cycles -> out_valid, out_data, out_src constant; readys 0; handoff on the first cycle out_ready=1.
REQ-036 rst pulsed low after 2 of 3 beats -> all outputs 0 immediately (asynchronously); after release, a fresh 3-beat window 4,1,0 yields out_data=4 with no stale value.

Source files
------------

// File: rtl/cmp_pool_sched.sv
// Two-requester max-pooling scheduler: a round-robin grant owns the datapath for
// a window of cfg_win beats, then the window maximum is offered downstream.
module cmp_pool_sched #(
    parameter int DATA_W = 4,
    parameter int WIN_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIN_W-1:0]  cfg_win,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req0_ready,
    output logic              req1_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_src,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t              state, state_nxt;
    logic                grant, grant_nxt;
    logic                last_win, last_win_nxt;
    logic [WIN_W-1:0]    win_len, win_len_nxt;
    logic [WIN_W-1:0]    count, count_nxt;
    logic [DATA_W-1:0]   max_reg, max_nxt;
    logic                beat_valid;
    logic [DATA_W-1:0]   beat_data;

    assign beat_valid = grant ? req1_valid : req0_valid;
    assign beat_data  = grant ? req1_data  : req0_data;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            grant    <= 1'b0;
            last_win <= 1'b1;  // requester 0 wins the first simultaneous request
            win_len  <= WIN_W'(1);
            count    <= '0;
            max_reg  <= '0;
        end else begin
            state    <= state_nxt;
            grant    <= grant_nxt;
            last_win <= last_win_nxt;
            win_len  <= win_len_nxt;
            count    <= count_nxt;
            max_reg  <= max_nxt;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt    = state;
        grant_nxt    = grant;
        last_win_nxt = last_win;
        win_len_nxt  = win_len;
        count_nxt    = count;
        max_nxt      = max_reg;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        out_valid    = 1'b0;

        case (state)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    grant_nxt   = (req0_valid && req1_valid) ? ~last_win : req1_valid;
                    win_len_nxt = (cfg_win == '0) ? WIN_W'(1) : cfg_win;
                    count_nxt   = '0;
                    state_nxt   = ACCUM;
                end
            end
            ACCUM: begin
                req0_ready = ~grant;
                req1_ready = grant;
                if (beat_valid) begin
                    // First beat loads unconditionally; ties keep the held maximum.
                    if (count == '0 || beat_data > max_reg)
                        max_nxt = beat_data;
                    count_nxt = count + WIN_W'(1);
                    if (count + WIN_W'(1) == win_len)
                        state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    last_win_nxt = grant;
                    state_nxt    = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign out_data = max_reg;
    assign out_src  = grant;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_cmp_pool_sched.sv
// Directed self-checking bench for cmp_pool_sched: each task drives one scenario
// and compares outputs against hand-computed values one step after the rising edge.
module tb_cmp_pool_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] cfg_win;
    logic       req0_valid, req1_valid;
    logic [3:0] req0_data, req1_data;
    logic       req0_ready, req1_ready;
    logic       out_valid, out_ready;
    logic [3:0] out_data;
    logic       out_src;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;
    logic [3:0] beats [8];

    cmp_pool_sched #(.DATA_W(4), .WIN_W(3)) dut (
        .clk(clk), .rst(rst), .cfg_win(cfg_win),
        .req0_valid(req0_valid), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_data(req1_data),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_src(out_src), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Streams beats[0..n-1] from one requester, advancing on each accepted beat.
    task automatic send_beats(input logic src, input int n, output int cycles);
        int  i;
        logic rdy;
        i = 0;
        cycles = 0;
        if (src) begin req1_valid = 1'b1; req1_data = beats[0]; end
        else     begin req0_valid = 1'b1; req0_data = beats[0]; end
        while (i < n && cycles < 40) begin
            rdy = src ? req1_ready : req0_ready;
            tick();
            cycles++;
            if (rdy) begin
                i++;
                if (i < n) begin
                    if (src) req1_data = beats[i];
                    else     req0_data = beats[i];
                end
            end
        end
        if (src) req1_valid = 1'b0;
        else     req0_valid = 1'b0;
        n_cmp++;
        if (i !== n) begin
            n_bad++;
            $display("FAIL send_beats_timeout: accepted %0d beats, required %0d", i, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        cfg_win = 3'd1; out_ready = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; req0_data = '0; req1_data = '0;
        tick(); tick();
        n_cmp++;
        if ({req0_ready, req1_ready, out_valid, out_src, busy, out_data} !== 9'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b required 0",
                     {req0_ready, req1_ready, out_valid, out_src, busy, out_data});
        end
        rst = 1'b1;
        tick();
        n_cmp++;
        if ({out_valid, busy} !== 2'b00) begin
            n_bad++;
            $display("FAIL post_reset_idle: got %b required 00", {out_valid, busy});
        end
    endtask

    task automatic test_basic_window();
        int cycles;
        cfg_win = 3'd3; out_ready = 1'b1;
        beats[0] = 4'd1; beats[1] = 4'd3; beats[2] = 4'd2;
        send_beats(1'b0, 3, cycles);
        n_cmp++;
        if (cycles !== 4) begin
            n_bad++;
            $display("FAIL basic_latency: got %0d cycles required 4", cycles);
        end
        n_cmp++;
        if ({out_valid, out_data, out_src} !== {1'b1, 4'd3, 1'b0}) begin
            n_bad++;
            $display("FAIL basic_result: got v=%b d=%0d s=%b required v=1 d=3 s=0",
                     out_valid, out_data, out_src);
        end
        tick();
        n_cmp++;
        if ({out_valid, busy} !== 2'b00) begin
            n_bad++;
            $display("FAIL basic_handoff: got %b required 00", {out_valid, busy});
        end
    endtask

    task automatic test_round_robin();
        logic saw_r1;
        saw_r1 = 1'b0;
        rst = 1'b0; tick(); rst = 1'b1; tick();
        cfg_win = 3'd2; out_ready = 1'b1;
        req0_valid = 1'b1; req0_data = 4'd5;
        req1_valid = 1'b1; req1_data = 4'd7;
        tick();
        saw_r1 |= req1_ready;
        tick();
        saw_r1 |= req1_ready;
        req0_data = 4'd9;
        tick();
        saw_r1 |= req1_ready;
        n_cmp++;
        if ({out_valid, out_data, out_src} !== {1'b1, 4'd9, 1'b0}) begin
            n_bad++;
            $display("FAIL rr_first: got v=%b d=%0d s=%b required v=1 d=9 s=0",
                     out_valid, out_data, out_src);
        end
        n_cmp++;
        if (saw_r1 !== 1'b0) begin
            n_bad++;
            $display("FAIL rr_ungranted_ready: got req1_ready=%b required 0", saw_r1);
        end
        // Both stay valid: requester 1 must now win and requester 0 must wait.
        req0_data = 4'd15;
        tick();
        tick();
        n_cmp++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            n_bad++;
            $display("FAIL rr_second_grant: got %b required 01", {req0_ready, req1_ready});
        end
        tick();
        req1_data = 4'd4;
        tick();
        n_cmp++;
        if ({out_valid, out_data, out_src} !== {1'b1, 4'd7, 1'b1}) begin
            n_bad++;
            $display("FAIL rr_second: got v=%b d=%0d s=%b required v=1 d=7 s=1",
                     out_valid, out_data, out_src);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
    endtask

    task automatic test_win_zero();
        cfg_win = 3'd0; out_ready = 1'b1;
        req1_valid = 1'b1; req1_data = 4'd6;
        tick();
        tick();
        req1_valid = 1'b0;
        n_cmp++;
        if ({out_valid, out_data, out_src} !== {1'b1, 4'd6, 1'b1}) begin
            n_bad++;
            $display("FAIL win_zero: got v=%b d=%0d s=%b required v=1 d=6 s=1",
                     out_valid, out_data, out_src);
        end
        tick();
    endtask

    task automatic test_stall_and_cfg_change();
        logic early;
        early = 1'b0;
        cfg_win = 3'd4; out_ready = 1'b1;
        req0_valid = 1'b1; req0_data = 4'd2;
        tick();
        cfg_win = 3'd1;
        tick();
        req0_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            early |= out_valid;
        end
        n_cmp++;
        if ({busy, req0_ready, early} !== 3'b110) begin
            n_bad++;
            $display("FAIL stall_hold: got busy,rdy,valid=%b required 110",
                     {busy, req0_ready, early});
        end
        req0_valid = 1'b1; req0_data = 4'd15;
        tick();
        tick();
        req0_data = 4'd0;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_count: got out_valid=%b after 3 beats required 0", out_valid);
        end
        tick();
        req0_valid = 1'b0;
        n_cmp++;
        if ({out_valid, out_data, out_src} !== {1'b1, 4'd15, 1'b0}) begin
            n_bad++;
            $display("FAIL stall_result: got v=%b d=%0d s=%b required v=1 d=15 s=0",
                     out_valid, out_data, out_src);
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic changed;
        changed = 1'b0;
        cfg_win = 3'd1; out_ready = 1'b0;
        req0_valid = 1'b1; req0_data = 4'd11;
        tick();
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_data = 4'd3;
        for (int i = 0; i < 5; i++) begin
            if ({out_valid, out_data, out_src, req0_ready, req1_ready} !==
                {1'b1, 4'd11, 1'b0, 1'b0, 1'b0})
                changed = 1'b1;
            tick();
        end
        n_cmp++;
        if (changed !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_hold: got unstable=%b required 0", changed);
        end
        out_ready = 1'b1;
        tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_handoff: got out_valid=%b required 0", out_valid);
        end
        // The waiting requester 1 beat was not lost.
        tick();
        tick();
        req1_valid = 1'b0;
        n_cmp++;
        if ({out_valid, out_data, out_src} !== {1'b1, 4'd3, 1'b1}) begin
            n_bad++;
            $display("FAIL bp_waiter: got v=%b d=%0d s=%b required v=1 d=3 s=1",
                     out_valid, out_data, out_src);
        end
        tick();
    endtask

    task automatic test_reset_mid_window();
        int   cycles;
        logic stale;
        stale = 1'b0;
        cfg_win = 3'd3; out_ready = 1'b1;
        req0_valid = 1'b1; req0_data = 4'd9;
        tick();
        tick();
        req0_data = 4'd8;
        tick();
        req0_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if ({req0_ready, req1_ready, out_valid, out_src, busy, out_data} !== 9'd0) begin
            n_bad++;
            $display("FAIL async_reset: got %b required 0",
                     {req0_ready, req1_ready, out_valid, out_src, busy, out_data});
        end
        tick();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            stale |= out_valid;
        end
        n_cmp++;
        if (stale !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_stale_valid: got %b required 0", stale);
        end
        beats[0] = 4'd4; beats[1] = 4'd1; beats[2] = 4'd0;
        send_beats(1'b0, 3, cycles);
        n_cmp++;
        if ({out_valid, out_data, out_src} !== {1'b1, 4'd4, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_fresh_window: got v=%b d=%0d s=%b required v=1 d=4 s=0",
                     out_valid, out_data, out_src);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic_window();
        test_round_robin();
        test_win_zero();
        test_stall_and_cfg_change();
        test_backpressure();
        test_reset_mid_window();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
